// File: rtl/rx_watchdog_ctrl_if.sv
// Control/status bundle between the packet-detect path, the watchdog and rx_watchdog_ctrl.
// master drives the control inputs; slave is the controller side.
interface rx_watchdog_ctrl_if #(
  parameter int CNT_WIDTH     = 16,
  parameter int RST_CNT_WIDTH = 16
);
  logic                     ctrl_enable;
  logic                     pkt_begin;
  logic                     pkt_end;
  logic                     wd_rst_req;
  logic [CNT_WIDTH-1:0]     settle_len;
  logic [CNT_WIDTH-1:0]     rst_len;
  logic [CNT_WIDTH-1:0]     holdoff_len;
  logic [CNT_WIDTH-1:0]     timeout_len;
  logic                     cnt_clear;
  logic                     wd_enable;
  logic                     receiver_rst;
  logic [RST_CNT_WIDTH-1:0] rst_count;
  logic [2:0]               state_out;

  modport master (
    output ctrl_enable, pkt_begin, pkt_end, wd_rst_req,
    output settle_len, rst_len, holdoff_len, timeout_len, cnt_clear,
    input  wd_enable, receiver_rst, rst_count, state_out
  );

  modport slave (
    input  ctrl_enable, pkt_begin, pkt_end, wd_rst_req,
    input  settle_len, rst_len, holdoff_len, timeout_len, cnt_clear,
    output wd_enable, receiver_rst, rst_count, state_out
  );
endinterface

// File: rtl/rx_watchdog_ctrl.sv
// Purpose: arms the rx watchdog after settle, stretches a trip into receiver_rst, then blanks (holdoff).
// Latency: outputs decode registered state; wd_rst_req in ARMED at cycle N drives receiver_rst from N+1.
// Backpressure: none; pulses are consumed or ignored per state. WATCHDOG_CTRL_TIMEOUT_EN adds an ARMED timeout.
module rx_watchdog_ctrl #(
  parameter int CNT_WIDTH     = 16,
  parameter int RST_CNT_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rstn,
  rx_watchdog_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_ARMED   = 3'd2,
    S_RESET   = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  state_t                   state, state_nxt;
  logic [CNT_WIDTH-1:0]     cnt, cnt_nxt;
  logic                     drop, drop_nxt;
  logic                     trip;
  logic                     tmo;
  logic [RST_CNT_WIDTH-1:0] trip_cnt;

`ifdef WATCHDOG_CTRL_TIMEOUT_EN
  logic [CNT_WIDTH-1:0] tcnt;

  assign tmo = (state == S_ARMED) && (tcnt == ONE);

  // Zero loaded on entry never reaches ONE, which disables the timeout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tcnt <= '0;
    end else if (state_nxt == S_ARMED && state != S_ARMED) begin
      tcnt <= bus.timeout_len;
    end else if (state == S_ARMED && tcnt != '0) begin
      tcnt <= tcnt - ONE;
    end
  end
`else
  logic unused_timeout;
  assign tmo            = 1'b0;
  assign unused_timeout = ^bus.timeout_len;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      cnt   <= '0;
      drop  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      drop  <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    drop_nxt  = drop;
    trip      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.ctrl_enable && bus.pkt_begin) begin
          if (bus.settle_len == '0) begin
            state_nxt = S_ARMED;
          end else begin
            state_nxt = S_SETTLE;
            cnt_nxt   = bus.settle_len;
          end
        end
      end
      S_SETTLE: begin
        if (!bus.ctrl_enable || bus.pkt_end) begin
          state_nxt = S_IDLE;
        end else if (cnt == ONE) begin
          state_nxt = S_ARMED;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      S_ARMED: begin
        // A trip beats pkt_end; a timeout only fires when the packet is not ending.
        if (!bus.ctrl_enable) begin
          state_nxt = S_IDLE;
        end else if (bus.wd_rst_req || (tmo && !bus.pkt_end)) begin
          state_nxt = S_RESET;
          cnt_nxt   = (bus.rst_len == '0) ? ONE : bus.rst_len;
          drop_nxt  = 1'b0;
          trip      = 1'b1;
        end else if (bus.pkt_end) begin
          state_nxt = S_IDLE;
        end
      end
      S_RESET: begin
        // The pulse always runs to completion; a disable seen during it skips holdoff.
        drop_nxt = drop | ~bus.ctrl_enable;
        if (cnt == ONE) begin
          if (drop || !bus.ctrl_enable || bus.holdoff_len == '0) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_HOLDOFF;
            cnt_nxt   = bus.holdoff_len;
          end
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      S_HOLDOFF: begin
        if (!bus.ctrl_enable || cnt == ONE) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      trip_cnt <= '0;
    end else if (bus.cnt_clear) begin
      trip_cnt <= '0;
    end else if (trip && trip_cnt != '1) begin
      trip_cnt <= trip_cnt + RST_CNT_WIDTH'(1);
    end
  end

  assign bus.wd_enable    = (state == S_ARMED);
  assign bus.receiver_rst = (state == S_RESET);
  assign bus.rst_count    = trip_cnt;
  assign bus.state_out    = state;
endmodule

// File: tb/tb_rx_watchdog_ctrl.sv
// Directed bench for rx_watchdog_ctrl: literal checks per scenario plus a per-cycle compare
// against a phase/remaining-cycles model of the controller.
module tb_rx_watchdog_ctrl;
  localparam int CW   = 16;
  localparam int RCW  = 8;  // narrow trip counter keeps the saturation run short
  localparam int CMAX = (1 << RCW) - 1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  rx_watchdog_ctrl_if #(.CNT_WIDTH(CW), .RST_CNT_WIDTH(RCW)) bus ();

  rx_watchdog_ctrl #(.CNT_WIDTH(CW), .RST_CNT_WIDTH(RCW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int k;
    k = 0;
    while (32'(bus.state_out) != 32'(s) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(bus.state_out), 32'(s));
  endtask

  // Model: phase + cycles left in the phase, updated on each rising edge.
  int m_state = 0, m_left = 0, m_tleft = 0, m_count = 0;
  bit m_drop = 1'b0;

  always @(posedge clk or negedge rstn) begin
    bit en, pb, pe, wd, inc, tmo;
    int rl;
    if (!rstn) begin
      m_state = 0; m_left = 0; m_tleft = 0; m_count = 0; m_drop = 1'b0;
    end else begin
      en = bus.ctrl_enable; pb = bus.pkt_begin; pe = bus.pkt_end; wd = bus.wd_rst_req;
      inc = 1'b0; tmo = 1'b0;
      rl = int'(bus.rst_len);
      case (m_state)
        0: if (en && pb) begin
             if (int'(bus.settle_len) == 0) begin
               m_state = 2; m_tleft = int'(bus.timeout_len);
             end else begin
               m_state = 1; m_left = int'(bus.settle_len);
             end
           end
        1: if (!en || pe) m_state = 0;
           else begin
             m_left--;
             if (m_left == 0) begin m_state = 2; m_tleft = int'(bus.timeout_len); end
           end
        2: begin
`ifdef WATCHDOG_CTRL_TIMEOUT_EN
             if (m_tleft > 0) begin m_tleft--; tmo = (m_tleft == 0); end
`endif
             if (!en) m_state = 0;
             else if (wd || (tmo && !pe)) begin
               m_state = 3; m_left = (rl == 0) ? 1 : rl; m_drop = 1'b0; inc = 1'b1;
             end else if (pe) m_state = 0;
           end
        3: begin
             m_drop = m_drop || !en;
             m_left--;
             if (m_left == 0) begin
               if (m_drop || int'(bus.holdoff_len) == 0) m_state = 0;
               else begin m_state = 4; m_left = int'(bus.holdoff_len); end
             end
           end
        default: if (!en) m_state = 0;
                 else begin m_left--; if (m_left == 0) m_state = 0; end
      endcase
      if (bus.cnt_clear) m_count = 0;
      else if (inc && m_count < CMAX) m_count++;
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      check("model_state", 32'(bus.state_out), 32'(m_state));
      check("model_wd_enable", 32'(bus.wd_enable), 32'(m_state == 2));
      check("model_receiver_rst", 32'(bus.receiver_rst), 32'(m_state == 3));
      check("model_rst_count", 32'(bus.rst_count), 32'(m_count));
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish by %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.ctrl_enable = 1'b0; bus.pkt_begin = 1'b0; bus.pkt_end = 1'b0; bus.wd_rst_req = 1'b0;
    bus.settle_len = '0; bus.rst_len = '0; bus.holdoff_len = '0; bus.timeout_len = '0;
    bus.cnt_clear = 1'b0;
    cyc(3);
    check("rst_state", 32'(bus.state_out), 0);
    check("rst_wd_enable", 32'(bus.wd_enable), 0);
    check("rst_receiver_rst", 32'(bus.receiver_rst), 0);
    check("rst_count", 32'(bus.rst_count), 0);
    rstn = 1'b1;
    bus.ctrl_enable = 1'b1;
    cyc(100);
    check("idle_state", 32'(bus.state_out), 0);
    check("idle_wd_enable", 32'(bus.wd_enable), 0);
    check("idle_count", 32'(bus.rst_count), 0);

    // Settle of 8 cycles; a mid-settle length change must not matter.
    bus.settle_len = 16'd8; bus.pkt_begin = 1'b1; cyc(1); bus.pkt_begin = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("settle_state", 32'(bus.state_out), 1);
      check("settle_wd_enable", 32'(bus.wd_enable), 0);
      if (i == 2) bus.settle_len = 16'd20;
      cyc(1);
    end
    check("armed_state", 32'(bus.state_out), 2);
    check("armed_wd_enable", 32'(bus.wd_enable), 1);
    cyc(20);
    bus.pkt_end = 1'b1; cyc(1); bus.pkt_end = 1'b0;
    check("end_state", 32'(bus.state_out), 0);
    check("end_wd_enable", 32'(bus.wd_enable), 0);

    // Trip with rst_len=4, holdoff=16, wd_rst_req held high throughout.
    bus.settle_len = 16'd2; bus.rst_len = 16'd4; bus.holdoff_len = 16'd16;
    bus.pkt_begin = 1'b1; cyc(1); bus.pkt_begin = 1'b0;
    wait_state(2, 10, "arm_for_trip");
    bus.wd_rst_req = 1'b1; cyc(1);
    for (int i = 0; i < 4; i++) begin
      check("trip_receiver_rst", 32'(bus.receiver_rst), 1);
      check("trip_state", 32'(bus.state_out), 3);
      if (i == 1) bus.rst_len = 16'd9;
      cyc(1);
    end
    check("trip_count", 32'(bus.rst_count), 1);
    for (int i = 0; i < 16; i++) begin
      check("holdoff_state", 32'(bus.state_out), 4);
      check("holdoff_receiver_rst", 32'(bus.receiver_rst), 0);
      if (i == 5) bus.pkt_begin = 1'b1;
      if (i == 6) bus.pkt_begin = 1'b0;
      cyc(1);
    end
    check("holdoff_done_state", 32'(bus.state_out), 0);
    cyc(10);
    check("held_req_idle_state", 32'(bus.state_out), 0);
    check("held_req_count", 32'(bus.rst_count), 1);

    // Request already high during settle: ignored until ARMED.
    bus.settle_len = 16'd3; bus.rst_len = 16'd4;
    bus.pkt_begin = 1'b1; cyc(1); bus.pkt_begin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("settle_ignores_req", 32'(bus.state_out), 1);
      cyc(1);
    end
    check("one_armed_cycle", 32'(bus.state_out), 2);
    cyc(1);
    bus.wd_rst_req = 1'b0;
    check("req_after_settle", 32'(bus.state_out), 3);
    check("req_after_settle_count", 32'(bus.rst_count), 2);
    wait_state(0, 40, "back_to_idle_1");

    // Trip and pkt_end together, rst_len=0 gives a single-cycle pulse.
    bus.settle_len = '0; bus.rst_len = '0; bus.holdoff_len = '0;
    bus.pkt_begin = 1'b1; cyc(1); bus.pkt_begin = 1'b0;
    check("zero_settle_armed", 32'(bus.state_out), 2);
    cyc(2);
    bus.wd_rst_req = 1'b1; bus.pkt_end = 1'b1; cyc(1);
    bus.wd_rst_req = 1'b0; bus.pkt_end = 1'b0;
    check("tie_state", 32'(bus.state_out), 3);
    check("tie_receiver_rst", 32'(bus.receiver_rst), 1);
    check("tie_count", 32'(bus.rst_count), 3);
    cyc(1);
    check("tie_pulse_end_state", 32'(bus.state_out), 0);
    check("tie_pulse_end_rst", 32'(bus.receiver_rst), 0);

    // Disable mid-RESET: full 6-cycle pulse, then IDLE without holdoff.
    bus.rst_len = 16'd6; bus.holdoff_len = 16'd10;
    bus.pkt_begin = 1'b1; cyc(1); bus.pkt_begin = 1'b0;
    bus.wd_rst_req = 1'b1; cyc(1); bus.wd_rst_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("drop_pulse_rst", 32'(bus.receiver_rst), 1);
      if (i == 2) bus.ctrl_enable = 1'b0;
      cyc(1);
    end
    check("drop_no_holdoff", 32'(bus.state_out), 0);
    check("drop_count", 32'(bus.rst_count), 4);
    bus.ctrl_enable = 1'b1;

    // Disable during SETTLE returns to IDLE next cycle.
    bus.settle_len = 16'd10;
    bus.pkt_begin = 1'b1; cyc(1); bus.pkt_begin = 1'b0;
    cyc(2); bus.ctrl_enable = 1'b0; cyc(1);
    check("drop_settle_state", 32'(bus.state_out), 0);
    bus.ctrl_enable = 1'b1;

    // Clear, then clear coincident with a trip.
    bus.cnt_clear = 1'b1; cyc(1); bus.cnt_clear = 1'b0;
    check("clear_count", 32'(bus.rst_count), 0);
    bus.settle_len = '0; bus.rst_len = 16'd1; bus.holdoff_len = '0;
    bus.pkt_begin = 1'b1; cyc(1); bus.pkt_begin = 1'b0;
    bus.wd_rst_req = 1'b1; bus.cnt_clear = 1'b1; cyc(1);
    bus.wd_rst_req = 1'b0; bus.cnt_clear = 1'b0;
    check("clear_vs_trip_state", 32'(bus.state_out), 3);
    check("clear_vs_trip_count", 32'(bus.rst_count), 0);
    wait_state(0, 10, "back_to_idle_2");

    // Saturation: continuous 3-cycle trips well past all-ones.
    bus.rst_len = '0;
    bus.pkt_begin = 1'b1; bus.wd_rst_req = 1'b1;
    cyc(3 * (CMAX + 6));
    check("saturated_count", 32'(bus.rst_count), 32'(CMAX));
    wait_state(2, 5, "sat_armed");
    bus.cnt_clear = 1'b1; cyc(1); bus.cnt_clear = 1'b0;
    check("sat_clear_vs_trip", 32'(bus.rst_count), 0);
    check("sat_clear_state", 32'(bus.state_out), 3);
    bus.pkt_begin = 1'b0; bus.wd_rst_req = 1'b0;
    wait_state(0, 10, "back_to_idle_3");

    // ARMED timeout of 50 cycles.
    bus.timeout_len = 16'd50; bus.rst_len = 16'd2;
    bus.pkt_begin = 1'b1; cyc(1); bus.pkt_begin = 1'b0;
    for (int i = 0; i < 50; i++) begin
      check("timeout_armed_state", 32'(bus.state_out), 2);
      check("timeout_armed_rst", 32'(bus.receiver_rst), 0);
      cyc(1);
    end
`ifdef WATCHDOG_CTRL_TIMEOUT_EN
    check("timeout_fires_rst", 32'(bus.receiver_rst), 1);
    check("timeout_count", 32'(bus.rst_count), 1);
    wait_state(0, 10, "timeout_idle");
`else
    cyc(10);
    check("no_timeout_still_armed", 32'(bus.state_out), 2);
    bus.pkt_end = 1'b1; cyc(1); bus.pkt_end = 1'b0;
    check("no_timeout_end_idle", 32'(bus.state_out), 0);
    check("no_timeout_count", 32'(bus.rst_count), 0);
`endif
    bus.timeout_len = '0;
    cyc(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
